// File: rtl/reset_seq_pkg.sv
// Shared types and default constants for the staged reset sequencer.
//
// Contents:
//   RSEQ_NUM_STAGES_DEF  - default number of staged reset outputs
//   RSEQ_STAGE_DELAY_DEF - default clocks between successive releases
//   rseq_state_e         - sequencer FSM state encoding
//
// Build option: RESET_SEQ_REVERSE_ASSERT_EN adds S_ASSERT, so that a soft
// reset asserts the stages one at a time in reverse order.
package reset_seq_pkg;

    localparam int unsigned RSEQ_NUM_STAGES_DEF  = 3;
    localparam int unsigned RSEQ_STAGE_DELAY_DEF = 16;

`ifdef RESET_SEQ_REVERSE_ASSERT_EN
    typedef enum logic [1:0] {
        S_HOLD   = 2'd0,
        S_DONE   = 2'd1,
        S_ACK    = 2'd2,
        S_ASSERT = 2'd3
    } rseq_state_e;
`else
    typedef enum logic [1:0] {
        S_HOLD   = 2'd0,
        S_DONE   = 2'd1,
        S_ACK    = 2'd2
    } rseq_state_e;
`endif

endpackage : reset_seq_pkg

// File: rtl/reset_seq_timer.sv
// Inter-stage delay timer for the reset sequencer.
//
// The counter holds the number of enabled cycles that remain before the next
// expiry. It runs STAGE_DELAY-1 down to 0, and expire_c marks the enabled
// cycle in which it reaches 0. On that cycle it wraps back to STAGE_DELAY-1,
// so back-to-back stages need no reload. STAGE_DELAY=1 therefore expires on
// every enabled cycle.
//
// Ports:
//   clk      - block clock
//   rst_n    - asynchronous active-low reset (same pin as the sequencer)
//   load     - restart a full STAGE_DELAY interval
//   en       - count this cycle
//   expire_c - combinational one-cycle pulse: interval complete this cycle
module reset_seq_timer
    import reset_seq_pkg::*;
#(
    parameter int unsigned STAGE_DELAY = RSEQ_STAGE_DELAY_DEF,
    parameter int unsigned CNT_W       = $clog2(STAGE_DELAY + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expire_c
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(STAGE_DELAY - 1);

    logic [CNT_W-1:0] cnt;

    // Remaining-cycles counter, wrapping on expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= RELOAD;
        end else if (load) begin
            cnt <= RELOAD;
        end else if (en) begin
            if (cnt == '0) begin
                cnt <= RELOAD;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    assign expire_c = en && (cnt == '0);

endmodule : reset_seq_timer

// File: rtl/reset_sequencer.sv
// Ordered per-domain reset generator for the BNN datapath.
//
// After the chip reset rst_n is released, stage_rst_n[0..N-1] are released
// in index order, STAGE_DELAY clocks apart. The order is IO/shift-in, then the
// layer engines, then the output classifier. Once every stage is out of reset,
// a four-phase soft_req/soft_ack handshake can re-run the whole sequence.
//
// Ports:
//   clk         - block clock
//   rst_n       - asynchronous active-low chip reset
//   soft_req    - soft-reset request (level, four-phase)
//   soft_ack    - soft-reset acknowledge (level, registered)
//   stage_rst_n - staged active-low resets; bit 0 is released first
//   rst_done    - all stages released (registered)
//   busy        - inverse of rst_done (registered)
//
// Build option: RESET_SEQ_REVERSE_ASSERT_EN makes a soft reset assert the
// stages N-1 down to 0, STAGE_DELAY apart, before the normal release. When it
// is undefined, all stages assert together. Power-up is the same in both builds.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned NUM_STAGES  = RSEQ_NUM_STAGES_DEF,
    parameter int unsigned STAGE_DELAY = RSEQ_STAGE_DELAY_DEF,
    parameter int unsigned CNT_W       = $clog2(STAGE_DELAY + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  soft_req,
    output logic                  soft_ack,
    output logic [NUM_STAGES-1:0] stage_rst_n,
    output logic                  rst_done,
    output logic                  busy
);

    localparam int unsigned      IDX_W    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

    rseq_state_e      state;
    logic [IDX_W-1:0] idx;
    logic             soft_pend;
    logic             trigger_c;
    logic             tmr_en_c;
    logic             expire_c;

    // One-hot mask that selects stage i.
    function automatic logic [NUM_STAGES-1:0] stage_bit(input logic [IDX_W-1:0] i);
        stage_bit = '0;
        for (int unsigned k = 0; k < NUM_STAGES; k++) begin
            if (i == IDX_W'(k)) begin
                stage_bit[k] = 1'b1;
            end
        end
    endfunction

    // A new request is only honoured from S_DONE with no acknowledge owed or
    // pending, so a request still held high after a completed handshake cannot
    // retrigger.
    assign trigger_c = (state == S_DONE) && !soft_pend && !soft_ack && soft_req;

`ifdef RESET_SEQ_REVERSE_ASSERT_EN
    assign tmr_en_c = (state == S_HOLD) || (state == S_ASSERT);
`else
    assign tmr_en_c = (state == S_HOLD);
`endif

    reset_seq_timer #(
        .STAGE_DELAY (STAGE_DELAY),
        .CNT_W       (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (trigger_c),
        .en       (tmr_en_c),
        .expire_c (expire_c)
    );

    // Sequencer FSM, stage index and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_HOLD;
            idx         <= '0;
            soft_pend   <= 1'b0;
            soft_ack    <= 1'b0;
            stage_rst_n <= '0;
            rst_done    <= 1'b0;
            busy        <= 1'b1;
        end else begin
            case (state)
                // Release one stage per expiry, strictly in index order.
                S_HOLD: begin
                    if (expire_c) begin
                        stage_rst_n <= stage_rst_n | stage_bit(idx);
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= S_DONE;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end

`ifdef RESET_SEQ_REVERSE_ASSERT_EN
                // idx names the most recently asserted stage; assert the one below it.
                S_ASSERT: begin
                    if (expire_c) begin
                        stage_rst_n <= stage_rst_n & ~stage_bit(idx - IDX_W'(1));
                        if (idx == IDX_W'(1)) begin
                            idx   <= '0;
                            state <= S_HOLD;
                        end else begin
                            idx <= idx - IDX_W'(1);
                        end
                    end
                end
`endif

                S_DONE: begin
                    if (soft_pend) begin
                        rst_done  <= 1'b1;
                        busy      <= 1'b0;
                        soft_ack  <= 1'b1;
                        soft_pend <= 1'b0;
                        state     <= S_ACK;
                    end else if (trigger_c) begin
                        rst_done  <= 1'b0;
                        busy      <= 1'b1;
                        soft_pend <= 1'b1;
`ifdef RESET_SEQ_REVERSE_ASSERT_EN
                        stage_rst_n <= stage_rst_n & ~stage_bit(LAST_IDX);
                        if (NUM_STAGES > 1) begin
                            idx   <= LAST_IDX;
                            state <= S_ASSERT;
                        end else begin
                            idx   <= '0;
                            state <= S_HOLD;
                        end
`else
                        stage_rst_n <= '0;
                        idx         <= '0;
                        state       <= S_HOLD;
`endif
                    end else begin
                        rst_done <= 1'b1;
                        busy     <= 1'b0;
                    end
                end

                // Hold the acknowledge until the requester withdraws.
                S_ACK: begin
                    if (!soft_req) begin
                        soft_ack <= 1'b0;
                        state    <= S_DONE;
                    end
                end

                default: begin
                    state <= S_HOLD;
                end
            endcase
        end
    end

endmodule : reset_sequencer
